// File: rtl/hpu_reset_sequencer_if.sv
// Soft-reset handshake bundle between the regif, the BSK cache, the cache
// and the datapath on one side and hpu_reset_sequencer on the other.
// master: the environment (regif / cache / datapath) driving requests and acks.
// slave : the sequencer answering them.
interface hpu_reset_sequencer_if;
  logic       hpu_reset;
  logic       hpu_reset_done;
  logic       reset_bsk_cache;
  logic       reset_bsk_cache_done;
  logic       reset_cache;
  logic       pipe_idle;
  logic       seq_busy;
  logic [2:0] seq_stage;
  logic       timeout_err;

  modport master (
    output hpu_reset,
    output reset_bsk_cache_done,
    output pipe_idle,
    input  hpu_reset_done,
    input  reset_bsk_cache,
    input  reset_cache,
    input  seq_busy,
    input  seq_stage,
    input  timeout_err
  );

  modport slave (
    input  hpu_reset,
    input  reset_bsk_cache_done,
    input  pipe_idle,
    output hpu_reset_done,
    output reset_bsk_cache,
    output reset_cache,
    output seq_busy,
    output seq_stage,
    output timeout_err
  );
endinterface

// File: rtl/hpu_reset_sequencer.sv
// HPU soft-reset sequencer (prc_clk domain).
// On a hpu_reset request: reset the BSK cache and wait for its ack, strobe
// reset_cache for CACHE_RST_CYCLES cycles, wait for the pipeline to drain,
// then hold hpu_reset_done until the request is released.
// Optional feature macro: HPU_RESET_SEQ_TIMEOUT_EN adds a watchdog on the
// BSK_RST and DRAIN wait states that sets a sticky timeout_err and forces
// the FSM forward. Without it timeout_err is tied low.
module hpu_reset_sequencer #(
  parameter int CACHE_RST_CYCLES = 16,
  parameter int TIMEOUT_CYCLES   = 65536
) (
  input  logic                  prc_clk,
  input  logic                  prc_arst,
  hpu_reset_sequencer_if.slave  seq_if
);

  localparam int CNT_MAX = (CACHE_RST_CYCLES > TIMEOUT_CYCLES) ? CACHE_RST_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    BSK_RST   = 3'd1,
    CACHE_RST = 3'd2,
    DRAIN     = 3'd3,
    DONE      = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               done_q;
  logic               bsk_q;
  logic               rc_q;
  logic               busy_q;
  logic [2:0]         stage_q;

`ifdef HPU_RESET_SEQ_TIMEOUT_EN
  logic               err_q, err_d;
  logic               wd_hit;
`endif

  // Next-state: cnt_q doubles as the CACHE_RST strobe counter, the
  // "first BSK_RST cycle" marker (zero means first cycle, stale ack ignored)
  // and, when built, the wait-state watchdog.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
`ifdef HPU_RESET_SEQ_TIMEOUT_EN
    err_d   = err_q;
    wd_hit  = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (seq_if.hpu_reset) begin
          state_d = BSK_RST;
`ifdef HPU_RESET_SEQ_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end
      end
      BSK_RST: begin
        if ((cnt_q != '0) && seq_if.reset_bsk_cache_done) begin
          state_d = CACHE_RST;
          cnt_d   = '0;
        end
`ifdef HPU_RESET_SEQ_TIMEOUT_EN
        else if (wd_hit) begin
          state_d = CACHE_RST;
          cnt_d   = '0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`else
        else begin
          // Only needs to be non-zero after the first cycle.
          cnt_d = CNT_W'(1);
        end
`endif
      end
      CACHE_RST: begin
        if (cnt_q == CNT_W'(CACHE_RST_CYCLES - 1)) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DRAIN: begin
        if (seq_if.pipe_idle) begin
          state_d = DONE;
          cnt_d   = '0;
        end
`ifdef HPU_RESET_SEQ_TIMEOUT_EN
        else if (wd_hit) begin
          state_d = DONE;
          cnt_d   = '0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      DONE: begin
        if (!seq_if.hpu_reset) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter and all outputs registered; outputs decode the next state
  // so they change on the same edge as the state.
  always_ff @(posedge prc_clk or posedge prc_arst) begin
    if (prc_arst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      bsk_q   <= 1'b0;
      rc_q    <= 1'b0;
      busy_q  <= 1'b0;
      stage_q <= 3'd0;
`ifdef HPU_RESET_SEQ_TIMEOUT_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= (state_d == DONE);
      bsk_q   <= (state_d == BSK_RST);
      rc_q    <= (state_d == CACHE_RST);
      busy_q  <= (state_d != IDLE);
      stage_q <= state_d;
`ifdef HPU_RESET_SEQ_TIMEOUT_EN
      err_q   <= err_d;
`endif
    end
  end

  assign seq_if.hpu_reset_done  = done_q;
  assign seq_if.reset_bsk_cache = bsk_q;
  assign seq_if.reset_cache     = rc_q;
  assign seq_if.seq_busy        = busy_q;
  assign seq_if.seq_stage       = stage_q;
`ifdef HPU_RESET_SEQ_TIMEOUT_EN
  assign seq_if.timeout_err     = err_q;
`else
  assign seq_if.timeout_err     = 1'b0;
`endif

endmodule

// File: tb/tb_hpu_reset_sequencer.sv
// Directed bench for hpu_reset_sequencer (CACHE_RST_CYCLES=16, TIMEOUT_CYCLES=64).
// Expected output vectors come from the sequence timeline: per-state dwell
// times are given to expv(), pushed to a queue as each cycle is driven and
// popped when the DUT outputs for that cycle are sampled.
module tb_hpu_reset_sequencer;

  localparam int N     = 16;
  localparam int NEVER = 1 << 30;
`ifdef HPU_RESET_SEQ_TIMEOUT_EN
  localparam int STALL = 50;
`else
  localparam int STALL = 100;
`endif

  logic clk = 1'b0;
  logic arst;
  int   tests = 0;
  int   fails = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  hpu_reset_sequencer_if bus ();

  hpu_reset_sequencer #(
    .CACHE_RST_CYCLES (N),
    .TIMEOUT_CYCLES   (64)
  ) dut (
    .prc_clk  (clk),
    .prc_arst (arst),
    .seq_if   (bus)
  );

  // {timeout_err, done, reset_bsk_cache, reset_cache, busy, stage[2:0]}
  function automatic logic [7:0] obs();
    return {bus.timeout_err, bus.hpu_reset_done, bus.reset_bsk_cache,
            bus.reset_cache, bus.seq_busy, bus.seq_stage};
  endfunction

  // Expected vector for output cycle j of a sequence whose request was
  // sampled at edge 0: BSK_RST for b cycles, CACHE_RST for N, DRAIN for d,
  // DONE up to cycle e, IDLE after; timeout_err from cycle errf on.
  function automatic logic [7:0] expv(int j, int b, int d, int e, int errf);
    logic [2:0] st;
    if (j >= 1 && j <= b)                 st = 3'd1;
    else if (j > b && j <= b + N)         st = 3'd2;
    else if (j > b + N && j <= b + N + d) st = 3'd3;
    else if (j > b + N + d && j <= e)     st = 3'd4;
    else                                  st = 3'd0;
    return {(j >= errf), (st == 3'd4), (st == 3'd1), (st == 3'd2), (st != 3'd0), st};
  endfunction

  task automatic check(input string tag, input logic [7:0] o, input logic [7:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, o, e);
    end
  endtask

  task automatic run_seq(input string tag, input int total, input int req_last,
                         input int ack_from, input int idle_from, input int b,
                         input int d, input int e, input int errf);
    for (int i = 0; i < total; i++) begin
      bus.hpu_reset            = (i <= req_last);
      bus.reset_bsk_cache_done = (i >= ack_from);
      bus.pipe_idle            = (i >= idle_from);
      exp_q.push_back(expv(i + 1, b, d, e, errf));
      @(posedge clk);
      #1;
      check($sformatf("%s_c%0d", tag, i + 1), obs(), exp_q.pop_front());
    end
  endtask

  task automatic idle_cycles(input string tag, input int n, input logic ack);
    for (int i = 0; i < n; i++) begin
      bus.hpu_reset            = 1'b0;
      bus.reset_bsk_cache_done = ack;
      bus.pipe_idle            = 1'b1;
      exp_q.push_back(8'h00);
      @(posedge clk);
      #1;
      check($sformatf("%s_%0d", tag, i), obs(), exp_q.pop_front());
    end
  endtask

  initial begin
    arst                     = 1'b1;
    bus.hpu_reset            = 1'b0;
    bus.reset_bsk_cache_done = 1'b0;
    bus.pipe_idle            = 1'b0;
    #1;
    check("reset_async", obs(), 8'h00);
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold", obs(), 8'h00);
    arst = 1'b0;
    idle_cycles("idle_after_reset", 3, 1'b0);

    // Nominal: ack at c5, pipe idle, release at c30.
    run_seq("nominal", 32, 29, 5, 0, 5, 1, 30, NEVER);

    // Stale ack held high before the request: BSK_RST still lasts 2 cycles.
    idle_cycles("stale_pre", 3, 1'b1);
    run_seq("stale", 32, 29, 0, 0, 2, 1, 30, NEVER);

    // Early release: request only c0-c3, done becomes a one-cycle pulse.
    idle_cycles("early_pre", 2, 1'b0);
    run_seq("early", 23, 3, 0, 0, 2, 1, 20, NEVER);

    // Drain stall: pipe busy for STALL cycles after CACHE_RST.
    idle_cycles("stall_pre", 2, 1'b0);
    run_seq("stall", STALL + 28, STALL + 24, 0, STALL + 18, 2, STALL, STALL + 25, NEVER);

    // Async reset in the middle of CACHE_RST, then a fresh sequence.
    idle_cycles("arst_pre", 2, 1'b0);
    run_seq("arst_a", 6, NEVER, 2, 0, 2, 1, NEVER, NEVER);
    #3;
    arst = 1'b1;
    #1;
    check("arst_async_clear", obs(), 8'h00);
    @(posedge clk);
    #1;
    check("arst_held", obs(), 8'h00);
    arst = 1'b0;
    run_seq("arst_restart", 28, 25, 1, 0, 2, 1, 26, NEVER);

`ifdef HPU_RESET_SEQ_TIMEOUT_EN
    // No ack: watchdog fires after 64 BSK_RST cycles, FSM proceeds.
    idle_cycles("tmo_pre", 2, 1'b0);
    run_seq("timeout", 84, 0, NEVER, 0, 64, 1, 82, 65);
    // Next request clears the sticky error.
    run_seq("err_clear", 3, NEVER, NEVER, 0, NEVER, 1, NEVER, NEVER);
`else
    // No watchdog: without an ack the sequencer stays in BSK_RST.
    idle_cycles("tmo_pre", 2, 1'b0);
    run_seq("no_timeout", 10000, NEVER, NEVER, 0, NEVER, 1, NEVER, NEVER);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
